// File: rtl/ft245_async_bridge_pkg.sv
// ----------------------------------------------------------------------------
// ft245_pkg
// Shared definitions for the FT245 asynchronous FIFO bridge:
//   - state_t  : protocol engine states
//   - served_t : which direction won the last arbitration (READ / WRITE)
//   - COUNT_W  : width of the per-state cycle counter
//   - cnt_load : counter load value for a state lasting 'clocks' cycles
// ----------------------------------------------------------------------------
package ft245_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RD_STROBE   = 3'd1,
    WR_SETUP    = 3'd2,
    WR_STROBE   = 3'd3,
    WR_HOLD     = 3'd4,
    RECOVER     = 3'd5,
    SIWU_STROBE = 3'd6
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } served_t;

  // A state exits when its counter reaches zero, so loading clocks-1 on
  // entry makes the state last exactly 'clocks' cycles.
  function automatic logic [COUNT_W-1:0] cnt_load(input int unsigned clocks);
    return COUNT_W'(clocks - 1);
  endfunction

endpackage

// File: rtl/ft245_async_bridge_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level input.
// Parameters:
//   RESET_VAL : value both flops take during reset
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronized output (two clocks of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ft245_async_bridge.sv
// ----------------------------------------------------------------------------
// ft245_async_bridge
// Protocol engine for FT245-style asynchronous FIFO pins. Turns the pin
// handshake (rxf_n/rd_n, txe_n/wr_n, siwu, bidirectional data) into internal
// valid/ready byte streams. The tristate pad lives one level up and is driven
// from fifo_d_out / fifo_d_oe.
//
// Optional feature macro: FIFO_SIWU_EN
//   defined   : after a completed write and SIWU_IDLE_CLOCKS idle cycles, a
//               send-immediate pulse (siwu low for WR_LOW_CLOCKS) is issued.
//   undefined : fifo_siwu is tied high, no idle counter or SIWU state logic.
//
// Ports:
//   clock, reset_n          : system clock, async active-low reset
//   fifo_d_in/out, fifo_d_oe: data pins (in, out, output enable)
//   fifo_rxf_n, fifo_txe_n  : host byte available / transmit room (async)
//   fifo_rd_n, fifo_wr_n    : read / write strobes (active low)
//   fifo_siwu               : send-immediate (active low)
//   rx_data/rx_valid/rx_ready : received byte stream
//   tx_data/tx_valid/tx_ready : byte stream to transmit
//   busy                    : engine not in IDLE
// ----------------------------------------------------------------------------
module ft245_async_bridge
  import ft245_pkg::*;
#(
  parameter int unsigned RD_LOW_CLOCKS    = 3,
  parameter int unsigned WR_SETUP_CLOCKS  = 1,
  parameter int unsigned WR_LOW_CLOCKS    = 3,
  parameter int unsigned WR_HOLD_CLOCKS   = 1,
  parameter int unsigned RECOVER_CLOCKS   = 4,
  parameter int unsigned SIWU_IDLE_CLOCKS = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] fifo_d_in,
  output logic [7:0] fifo_d_out,
  output logic       fifo_d_oe,
  input  logic       fifo_rxf_n,
  input  logic       fifo_txe_n,
  output logic       fifo_rd_n,
  output logic       fifo_wr_n,
  output logic       fifo_siwu,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  state_t               r_state;
  served_t              r_last_served;
  logic [COUNT_W-1:0]   r_cnt;
  logic                 r_rd_n;
  logic                 r_wr_n;
  logic                 r_d_oe;
  logic [7:0]           r_d_out;
  logic [7:0]           r_rx_data;
  logic                 r_rx_valid;

  logic w_rxf_n_s;
  logic w_txe_n_s;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_rd_win;
  logic w_tx_ready;
  logic w_wr_start;
  logic w_cnt_zero;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rxf (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (fifo_rxf_n),
    .o_q     (w_rxf_n_s)
  );

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_txe (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (fifo_txe_n),
    .o_q     (w_txe_n_s)
  );

  assign w_rd_ok    = (r_state == IDLE) && !w_rxf_n_s && !r_rx_valid;
  assign w_wr_ok    = (r_state == IDLE) && !w_txe_n_s && tx_valid;
  // With both sides eligible, serve the direction not served last time.
  assign w_rd_win   = w_rd_ok && (!w_wr_ok || (r_last_served == WRITE));
  assign w_tx_ready = (r_state == IDLE) && !w_txe_n_s && !w_rd_win;
  assign w_wr_start = tx_valid && w_tx_ready;
  assign w_cnt_zero = (r_cnt == '0);

`ifdef FIFO_SIWU_EN
  localparam int unsigned     IDLE_W     = $clog2(SIWU_IDLE_CLOCKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(SIWU_IDLE_CLOCKS);

  logic              r_siwu_n;
  logic              r_siwu_pending;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_siwu_start;

  assign w_siwu_start = (r_state == IDLE) && !w_rd_win && !w_wr_start &&
                        r_siwu_pending && (r_idle_cnt == IDLE_LIMIT);
  assign fifo_siwu    = r_siwu_n;
`else
  logic w_unused_siwu_cfg;
  assign w_unused_siwu_cfg = (SIWU_IDLE_CLOCKS != 0);
  assign fifo_siwu         = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_last_served <= WRITE;
      r_cnt         <= '0;
      r_rd_n        <= 1'b1;
      r_wr_n        <= 1'b1;
      r_d_oe        <= 1'b0;
      r_d_out       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
`ifdef FIFO_SIWU_EN
      r_siwu_n       <= 1'b1;
      r_siwu_pending <= 1'b0;
      r_idle_cnt     <= '0;
`endif
    end else begin
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_rd_win) begin
            r_state       <= RD_STROBE;
            r_rd_n        <= 1'b0;
            r_cnt         <= cnt_load(RD_LOW_CLOCKS);
            r_last_served <= READ;
          end else if (w_wr_start) begin
            r_state       <= WR_SETUP;
            r_d_oe        <= 1'b1;
            r_d_out       <= tx_data;
            r_cnt         <= cnt_load(WR_SETUP_CLOCKS);
            r_last_served <= WRITE;
          end
`ifdef FIFO_SIWU_EN
          else if (w_siwu_start) begin
            r_state        <= SIWU_STROBE;
            r_siwu_n       <= 1'b0;
            r_siwu_pending <= 1'b0;
            r_cnt          <= cnt_load(WR_LOW_CLOCKS);
          end
`endif
        end

        RD_STROBE: begin
          if (w_cnt_zero) begin
            r_rx_data  <= fifo_d_in;
            r_rx_valid <= 1'b1;
            r_rd_n     <= 1'b1;
            r_state    <= RECOVER;
            r_cnt      <= cnt_load(RECOVER_CLOCKS);
          end else begin
            r_cnt <= r_cnt - COUNT_W'(1);
          end
        end

        WR_SETUP: begin
          if (w_cnt_zero) begin
            r_wr_n  <= 1'b0;
            r_state <= WR_STROBE;
            r_cnt   <= cnt_load(WR_LOW_CLOCKS);
          end else begin
            r_cnt <= r_cnt - COUNT_W'(1);
          end
        end

        // txe_n is not consulted here: once wr_n is low the cycle completes.
        WR_STROBE: begin
          if (w_cnt_zero) begin
            r_wr_n  <= 1'b1;
            r_state <= WR_HOLD;
            r_cnt   <= cnt_load(WR_HOLD_CLOCKS);
          end else begin
            r_cnt <= r_cnt - COUNT_W'(1);
          end
        end

        WR_HOLD: begin
          if (w_cnt_zero) begin
            r_d_oe  <= 1'b0;
            r_state <= RECOVER;
            r_cnt   <= cnt_load(RECOVER_CLOCKS);
`ifdef FIFO_SIWU_EN
            r_siwu_pending <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt - COUNT_W'(1);
          end
        end

`ifdef FIFO_SIWU_EN
        SIWU_STROBE: begin
          if (w_cnt_zero) begin
            r_siwu_n <= 1'b1;
            r_state  <= RECOVER;
            r_cnt    <= cnt_load(RECOVER_CLOCKS);
          end else begin
            r_cnt <= r_cnt - COUNT_W'(1);
          end
        end
`endif

        // Covers the synchronizer lag on rxf_n/txe_n so a stale "ready"
        // cannot trigger a second transfer.
        RECOVER: begin
          if (w_cnt_zero) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - COUNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase

`ifdef FIFO_SIWU_EN
      // Counts quiet IDLE cycles; any transfer or non-IDLE cycle restarts it.
      if ((r_state == IDLE) && !w_rd_win && !w_wr_start && !w_siwu_start) begin
        if (r_idle_cnt != IDLE_LIMIT) begin
          r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
      end else begin
        r_idle_cnt <= '0;
      end
`endif
    end
  end

  assign fifo_rd_n  = r_rd_n;
  assign fifo_wr_n  = r_wr_n;
  assign fifo_d_oe  = r_d_oe;
  assign fifo_d_out = r_d_out;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign tx_ready   = w_tx_ready;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/ft245_async_bridge.md
Name: ft245_async_bridge

Overview:
- Protocol engine for the FT245-style asynchronous FIFO pins on the bring-up board.
- Converts the pin-level handshake (rxf_n/rd_n, txe_n/wr_n, siwu, 8-bit bidirectional data) into internal valid/ready byte streams.
- Sits directly downstream of the pins and replaces the static pin-exercising logic. The top level instantiates the tristate pad using fifo_d_out and fifo_d_oe.

Parameters:
- RD_LOW_CLOCKS, 3: cycles rd_n is held low; data is sampled on the last low cycle. Range 1..255.
- WR_SETUP_CLOCKS, 1: cycles data is driven before wr_n falls. Range 1..255.
- WR_LOW_CLOCKS, 3: cycles wr_n is held low. Range 1..255.
- WR_HOLD_CLOCKS, 1: cycles data stays driven after wr_n rises. Range 1..255.
- RECOVER_CLOCKS, 4: idle cycles after any strobe before IDLE. Minimum 3, because synchronizer lag must not cause a double transfer.
- SIWU_IDLE_CLOCKS, 1000: write-idle cycles before a send-immediate pulse. Used only with FIFO_SIWU_EN.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- fifo_d_in  in  8  data pins as input
- fifo_d_out  out  8  data pins as output
- fifo_d_oe  out  1  1 = drive the data pins
- fifo_rxf_n  in  1  low = host byte available
- fifo_txe_n  in  1  low = room in the transmit FIFO
- fifo_rd_n  out  1  read strobe, active low
- fifo_wr_n  out  1  write strobe, active low
- fifo_siwu  out  1  send-immediate, active low
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  consumer accepts rx_data
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  bridge accepts tx_data
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - fifo_rd_n=1, fifo_wr_n=1, fifo_siwu=1, fifo_d_oe=0, fifo_d_out=0.
  - rx_valid=0, rx_data=0, state=IDLE, last_served=WRITE, all counters=0.
  - Reset mid-strobe releases the strobe at once; any in-flight byte is discarded.
- Input synchronization: fifo_rxf_n and fifo_txe_n pass through 2-flop synchronizers. Their reset value is 1 (not ready).
- Eligibility, evaluated in IDLE only:
  - rd_ok = synced rxf_n==0 && !rx_valid.
  - wr_ok = synced txe_n==0 && tx_valid.
- Arbitration:
  - Only one eligible: serve it.
  - Both eligible: serve the opposite of last_served. After reset, a read wins first.
- tx_ready is combinational: 1 only when state==IDLE, synced txe_n==0, and read does not win this cycle. The handshake (tx_valid && tx_ready) captures tx_data into fifo_d_out.
- Read path:
  - IDLE -> RD_STROBE: rd_n=0 for RD_LOW_CLOCKS cycles.
  - On the last low cycle, rx_data <= fifo_d_in and rx_valid <= 1.
  - RD_STROBE -> RECOVER with rd_n=1, for RECOVER_CLOCKS cycles, then IDLE.
  - Read latency: rd_n falls 1 cycle after eligibility; rx_valid rises RD_LOW_CLOCKS cycles after rd_n falls.
- Write path, with d_oe=1 from WR_SETUP through WR_HOLD inclusive:
  - IDLE -> WR_SETUP (WR_SETUP_CLOCKS).
  - -> WR_STROBE: wr_n=0 for WR_LOW_CLOCKS.
  - -> WR_HOLD (WR_HOLD_CLOCKS).
  - -> RECOVER: d_oe=0.
  - -> IDLE.
- rx output register:
  - rx_valid clears on rx_valid && rx_ready.
  - rx_data is stable while rx_valid=1.
  - No new read starts while rx_valid=1.
  - A clear and a read start in the same cycle are legal: the read completes later.
- Counters are 8 bits and load PARAM-1 on state entry. The state exits when the counter is 0, so each state lasts exactly PARAM cycles.
- fifo_txe_n rising during WR_STROBE does not abort the cycle.

Optional Feature:
- Macro FIFO_SIWU_EN.
- Defined:
  - A pending flag sets on each completed write and clears on a siwu pulse.
  - An idle counter counts IDLE cycles with no transfer and resets on any transfer.
  - When pending && counter == SIWU_IDLE_CLOCKS: go IDLE -> SIWU_STROBE with siwu=0 for WR_LOW_CLOCKS, then RECOVER.
  - SIWU has the lowest arbitration priority.
- Undefined: fifo_siwu is tied to 1 and no idle counter or SIWU state is synthesized.

Decomposition:
- Package ft245_pkg holds:
  - state encodings: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, RECOVER, SIWU_STROBE;
  - COUNT_W=8;
  - READ/WRITE codes for last_served.
- Sub-module sync_2ff: parameterized reset value, used twice.

Test Plan:
- Host byte 0xA5 with rxf_n low, rx_ready=1 -> rd_n low 3 cycles; rx_data=0xA5 and rx_valid=1 after 3 cycles; rd_n high ≥4 cycles before the next strobe.
- tx_valid with 0x3C, txe_n low -> d_oe high 5 cycles; wr_n low exactly 3 cycles; fifo_d_out=0x3C throughout; tx_ready pulses once.
- Both rd_ok and wr_ok held continuously -> strobes alternate read, write, read, write, with the read first after reset.
- rx_ready=0 with rxf_n held low -> exactly one read, then rd_n stays high until rx_ready=1.
- reset_n low in the 2nd cycle of WR_STROBE -> wr_n=1 and d_oe=0 asynchronously; no further strobe until rxf_n/txe_n pass the synchronizer again.
- FIFO_SIWU_EN, SIWU_IDLE_CLOCKS=10, one write then idle -> siwu low 3 cycles starting 10 idle cycles after the write; no second pulse without a new write.
